// File: rtl/mult_ctrl.sv
// Control FSM for the shift-add multiplier datapath: sequences clr, ld, then
// WIDTH add steps separated by multiplier/product shifts, and pulses done.
module mult_ctrl #(
  parameter int WIDTH    = 4,
  parameter bit COND_ADD = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic b_lsb,
  output logic clr,
  output logic ld,
  output logic ldp,
  output logic shb,
  output logic shp,
  output logic busy,
  output logic done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CLR  = 3'd1,
    S_LOAD = 3'd2,
    S_ADD  = 3'd3,
    S_SHB  = 3'd4,
    S_SHP  = 3'd5,
    S_DONE = 3'd6
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;
  logic             clr_r;
  logic             ld_r;
  logic             add_r;
  logic             shb_r;
  logic             shp_r;
  logic             busy_r;
  logic             done_r;

  // State and iteration counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state and counter update; the last ADD goes straight to DONE.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_s = S_CLR;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_CLR: begin
        state_s = S_LOAD;
        cnt_s   = '0;
      end
      S_LOAD: state_s = S_ADD;
      S_ADD: begin
        if (cnt_r < LAST_ITER) begin
          state_s = S_SHB;
        end else begin
          state_s = S_DONE;
        end
      end
      S_SHB: state_s = S_SHP;
      S_SHP: begin
        state_s = S_ADD;
        cnt_s   = cnt_r + CNT_W'(1);
      end
      S_DONE:  state_s = S_IDLE;
      default: begin
        state_s = S_IDLE;
        cnt_s   = '0;
      end
    endcase
  end

  // Strobe registers track the state register one-hot; reset clears them at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_r  <= 1'b0;
      ld_r   <= 1'b0;
      add_r  <= 1'b0;
      shb_r  <= 1'b0;
      shp_r  <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      clr_r  <= (state_s == S_CLR);
      ld_r   <= (state_s == S_LOAD);
      add_r  <= (state_s == S_ADD);
      shb_r  <= (state_s == S_SHB);
      shp_r  <= (state_s == S_SHP);
      busy_r <= (state_s != S_IDLE);
      done_r <= (state_s == S_DONE);
    end
  end

  assign clr  = clr_r;
  assign ld   = ld_r;
  // Only combinational term: with COND_ADD the add is skipped for a zero multiplier bit.
  assign ldp  = add_r & (b_lsb | ~COND_ADD);
  assign shb  = shb_r;
  assign shp  = shp_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_mult_ctrl.sv
// Bench for mult_ctrl: two controllers (COND_ADD=0 and 1) each drive a
// behavioural shift-add datapath; a scoreboard checks product and strobe trace.
module tb_mult_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] da;
  logic [3:0] db;
  logic [1:0] b_lsb_i;
  logic [1:0] clr_o, ld_o, ldp_o, shb_o, shp_o, busy_o, done_o;

  logic [3:0] a_r [2];
  logic [3:0] b_r [2];
  logic [7:0] p_r [2];

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] exp_p0 [$];
  logic [7:0] exp_p1 [$];
  string      exp_t0 [$];
  string      exp_t1 [$];
  string      trace  [2];

  mult_ctrl #(.WIDTH(4), .COND_ADD(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .b_lsb(b_lsb_i[0]),
    .clr(clr_o[0]), .ld(ld_o[0]), .ldp(ldp_o[0]), .shb(shb_o[0]),
    .shp(shp_o[0]), .busy(busy_o[0]), .done(done_o[0])
  );

  mult_ctrl #(.WIDTH(4), .COND_ADD(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .b_lsb(b_lsb_i[1]),
    .clr(clr_o[1]), .ld(ld_o[1]), .ldp(ldp_o[1]), .shb(shb_o[1]),
    .shp(shp_o[1]), .busy(busy_o[1]), .done(done_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign b_lsb_i[0] = b_r[0][0];
  assign b_lsb_i[1] = b_r[1][0];

  // Datapath: adds A<<3 into P when the multiplier LSB is set, then shifts right.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (clr_o[k]) begin
        a_r[k] <= 4'h0;
        b_r[k] <= 4'h0;
        p_r[k] <= 8'h00;
      end else if (ld_o[k]) begin
        a_r[k] <= da;
        b_r[k] <= db;
      end else if (ldp_o[k]) begin
        p_r[k] <= p_r[k] + (b_r[k][0] ? {1'b0, a_r[k], 3'b000} : 8'h00);
      end else if (shb_o[k]) begin
        b_r[k] <= {1'b0, b_r[k][3:1]};
      end else if (shp_o[k]) begin
        p_r[k] <= {1'b0, p_r[k][7:1]};
      end
    end
  end

  function automatic string strobe_code(int k);
    if ($countones({clr_o[k], ld_o[k], ldp_o[k], shb_o[k], shp_o[k], done_o[k]}) > 1) return "X";
    if (clr_o[k])  return "C";
    if (ld_o[k])   return "L";
    if (ldp_o[k])  return "A";
    if (shb_o[k])  return "B";
    if (shp_o[k])  return "S";
    if (done_o[k]) return "D";
    return "a";
  endfunction

  // Expected busy-cycle trace: 'A' an ADD with ldp, 'a' an ADD whose add is skipped.
  function automatic string exp_trace(logic [3:0] mul, bit cond);
    string s;
    s = "CL";
    for (int i = 0; i < 4; i++) begin
      s = {s, (cond && !mul[i]) ? "a" : "A"};
      if (i < 3) s = {s, "BS"};
    end
    s = {s, "D"};
    return s;
  endfunction

  task automatic check_done(int k);
    logic [7:0] ep;
    string      et;
    compared = compared + 1;
    if ((k == 0 && exp_p0.size() == 0) || (k == 1 && exp_p1.size() == 0)) begin
      mismatched = mismatched + 1;
      $display("FAIL unexpected_done inst%0d: got done=1, required no done (trace %s)", k, trace[k]);
    end else begin
      if (k == 0) begin
        ep = exp_p0.pop_front();
        et = exp_t0.pop_front();
      end else begin
        ep = exp_p1.pop_front();
        et = exp_t1.pop_front();
      end
      if (p_r[k] !== ep) begin
        mismatched = mismatched + 1;
        $display("FAIL product inst%0d: got p=%h, required %h", k, p_r[k], ep);
      end
      compared = compared + 1;
      if (trace[k] != et) begin
        mismatched = mismatched + 1;
        $display("FAIL strobe_trace inst%0d: got %s, required %s", k, trace[k], et);
      end
    end
    trace[k] = "";
  endtask

  // Monitor: builds the per-run strobe trace and scores each done pulse.
  initial begin
    trace[0] = "";
    trace[1] = "";
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (!rst_n) begin
          trace[k] = "";
        end else begin
          if (busy_o[k]) trace[k] = {trace[k], strobe_code(k)};
          if (done_o[k]) check_done(k);
        end
      end
    end
  end

  task automatic check_outputs_zero(string name);
    logic [13:0] v;
    v = {clr_o, ld_o, ldp_o, shb_o, shp_o, busy_o, done_o};
    compared = compared + 1;
    if (v !== 14'h0) begin
      mismatched = mismatched + 1;
      $display("FAIL %s: got outputs=%h, required 0000", name, v);
    end
  endtask

  task automatic push_run(logic [3:0] mcand, logic [3:0] mul, logic [7:0] prod);
    exp_p0.push_back(prod);
    exp_t0.push_back(exp_trace(mul, 1'b0));
    exp_p1.push_back(prod);
    exp_t1.push_back(exp_trace(mul, 1'b1));
    da = mcand;
    db = mul;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_drain(string name);
    for (int i = 0; i < 60 && (exp_p0.size() != 0 || exp_p1.size() != 0); i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    compared = compared + 1;
    if (exp_p0.size() != 0 || exp_p1.size() != 0) begin
      mismatched = mismatched + 1;
      $display("FAIL %s_timeout: got %0d/%0d runs pending, required 0", name, exp_p0.size(), exp_p1.size());
      exp_p0.delete();
      exp_t0.delete();
      exp_p1.delete();
      exp_t1.delete();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    da    = 4'h0;
    db    = 4'h0;
    #3;
    check_outputs_zero("reset_outputs");
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    push_run(4'b1011, 4'b1101, 8'h8F);
    pulse_start();
    wait_drain("run_b_d");

    push_run(4'hF, 4'hF, 8'hE1);
    pulse_start();
    wait_drain("run_f_f");

    push_run(4'h0, 4'h9, 8'h00);
    pulse_start();
    wait_drain("run_0_9");

    push_run(4'h6, 4'h7, 8'h2A);
    pulse_start();
    wait_drain("run_6_7");

    push_run(4'h5, 4'h0, 8'h00);
    pulse_start();
    wait_drain("run_5_0");

    // start re-pulsed during the ADD of iteration 1 must be ignored
    push_run(4'b1011, 4'b1101, 8'h8F);
    pulse_start();
    repeat (5) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_drain("repulse");

    // start held high: two back-to-back runs
    push_run(4'h3, 4'h5, 8'h0F);
    push_run(4'h3, 4'h5, 8'h0F);
    start = 1'b1;
    repeat (20) @(posedge clk);
    #1 start = 1'b0;
    wait_drain("start_held");

    // reset during the iteration-2 ADD aborts the run with no done
    da = 4'b1011;
    db = 4'b1101;
    pulse_start();
    repeat (8) @(posedge clk);
    #2;
    compared = compared + 1;
    if (busy_o !== 2'b11) begin
      mismatched = mismatched + 1;
      $display("FAIL busy_before_abort: got %b, required 11", busy_o);
    end
    rst_n = 1'b0;
    #1;
    check_outputs_zero("async_abort");
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    check_outputs_zero("idle_after_abort");

    push_run(4'b1011, 4'b1101, 8'h8F);
    pulse_start();
    wait_drain("after_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
